// File: rtl/fpu_rr_arbiter.sv
// Round-robin front end that shares one FPU between NUM_REQ requesters.
// Requests carry the requester index in the FPU tag, and responses are routed back by that tag.
module fpu_rr_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int WIDTH        = 16,
    parameter int NUM_OPERANDS = 3,
    parameter int MAX_OUT      = 4,
    parameter int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ*NUM_OPERANDS*WIDTH-1:0] req_operands,
    input  logic [NUM_REQ*4-1:0]                  req_op,
    output logic                                  fpu_in_valid,
    input  logic                                  fpu_in_ready,
    output logic [NUM_OPERANDS*WIDTH-1:0]         fpu_operands,
    output logic [3:0]                            fpu_op,
    output logic [ID_W-1:0]                       fpu_tag,
    input  logic                                  fpu_out_valid,
    output logic                                  fpu_out_ready,
    input  logic [WIDTH-1:0]                      fpu_result,
    input  logic [4:0]                            fpu_status,
    input  logic [ID_W-1:0]                       fpu_tag_o,
    output logic [NUM_REQ-1:0]                    rsp_valid,
    input  logic [NUM_REQ-1:0]                    rsp_ready,
    output logic [WIDTH-1:0]                      rsp_result,
    output logic [4:0]                            rsp_status,
    output logic [3:0]                            outstanding,
    output logic                                  busy,
    output logic                                  dbg_locked
);
    localparam int OPW = NUM_OPERANDS * WIDTH;

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
    // once valid is raised it stays high with stable payload until that transfer.
    typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} lock_state_e;

    lock_state_e     lock_q;
    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] locked_id_q;
    logic [3:0]      outstanding_q;
    logic [3:0]      outstanding_d;

    logic            found;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] scan_idx;
    logic [ID_W-1:0] sel_id;
    logic            locked;
    logic            can_issue;
    logic            issue_fire;
    logic            rsp_fire;
    logic            tag_ok;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = ID_W'((32'(rr_ptr_q) + 32'(k)) % 32'(NUM_REQ));
            if (!found && req_valid[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    assign locked     = (lock_q == ST_LOCKED);
    assign can_issue  = (outstanding_q < 4'(MAX_OUT));
    assign sel_id     = locked ? locked_id_q : winner;
    assign fpu_in_valid = rst & (locked | (found & can_issue));
    assign issue_fire = fpu_in_valid & fpu_in_ready;
    assign fpu_tag    = sel_id;
    assign dbg_locked = locked;

    always_comb begin
        fpu_operands = '0;
        fpu_op       = '0;
        req_ready    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_id == ID_W'(i)) begin
                fpu_operands = req_operands[i*OPW +: OPW];
                fpu_op       = req_op[i*4 +: 4];
                req_ready[i] = issue_fire;
            end
        end
    end

    // A tag that matches no requester leaves every rsp_valid low and never accepts.
    always_comb begin
        rsp_valid     = '0;
        fpu_out_ready = 1'b0;
        tag_ok        = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (fpu_tag_o == ID_W'(i)) begin
                tag_ok        = 1'b1;
                rsp_valid[i]  = rst & fpu_out_valid;
                fpu_out_ready = rst & rsp_ready[i];
            end
        end
    end

    assign rsp_result = fpu_result;
    assign rsp_status = fpu_status;
    assign rsp_fire   = fpu_out_valid & fpu_out_ready;

    always_comb begin
        outstanding_d = outstanding_q;
        case ({issue_fire, rsp_fire})
            2'b10:   outstanding_d = outstanding_q + 4'd1;
            2'b01:   outstanding_d = (outstanding_q == 4'd0) ? 4'd0 : outstanding_q - 4'd1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    assign outstanding = outstanding_q;
    assign busy        = (outstanding_q != 4'd0) | fpu_in_valid;

    // Selection freezes while an offered request waits for fpu_in_ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_q        <= ST_IDLE;
            rr_ptr_q      <= '0;
            locked_id_q   <= '0;
            outstanding_q <= 4'd0;
        end else begin
            outstanding_q <= outstanding_d;
            if (issue_fire) begin
                lock_q   <= ST_IDLE;
                rr_ptr_q <= (sel_id == ID_W'(NUM_REQ - 1)) ? '0 : sel_id + ID_W'(1);
            end else if (fpu_in_valid && !locked) begin
                lock_q      <= ST_LOCKED;
                locked_id_q <= winner;
            end
        end
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
        rsp_fire |-> (outstanding_q != 4'd0));

    a_tag_in_range: assert property (@(posedge clk) disable iff (!rst)
        fpu_out_valid |-> tag_ok);

endmodule
